// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - tinymips LW/SW load/store unit
// Decodes LW/SW, forms the effective address, runs the memory handshake and returns load write-back.
module mips_lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        accept;
  logic [5:0]  opcode;
  logic [31:0] eff_addr;
  logic        op_ok;
  logic        aligned;
  logic        timeout;
  logic        unused_rs_field;

  assign unused_rs_field = ^instr[25:21];

  assign accept   = (state == IDLE) && instr_valid;
  assign opcode   = instr[31:26];
  assign eff_addr = rs_data + {{16{instr[15]}}, instr[15:0]};
  assign op_ok    = (opcode == OP_LW) || (opcode == OP_SW);
  assign aligned  = (eff_addr[1:0] == 2'b00);
  // An ack in the last allowed cycle takes priority over the timeout.
  assign timeout  = (state == REQ) && !mem_ack && (wait_cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && op_ok && aligned) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_nxt = mem_we ? IDLE : WB;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    mem_req     = (state == REQ);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      wb_valid  <= 1'b0;
      wb_addr   <= 5'h0;
      wb_data   <= 32'h0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      wait_cnt  <= 8'h0;
    end else begin
      err      <= 1'b0;
      wb_valid <= 1'b0;
      if (accept) begin
        mem_we    <= (opcode == OP_SW);
        mem_addr  <= eff_addr;
        mem_wdata <= rt_data;
        wb_addr   <= instr[20:16];
        wait_cnt  <= 8'h0;
        if (!op_ok) begin
          err      <= 1'b1;
          err_code <= 2'b01;
        end else if (!aligned) begin
          err      <= 1'b1;
          err_code <= 2'b10;
        end
      end else if (state == REQ) begin
        if (mem_ack) begin
          if (!mem_we) begin
            wb_data  <= mem_rdata;
            // Register 0 is hardwired; WB is still visited but no write strobe.
            wb_valid <= (wb_addr != 5'h0);
          end
        end else begin
          wait_cnt <= wait_cnt + 8'h1;
          if (timeout) begin
            err      <= 1'b1;
            err_code <= 2'b11;
          end
        end
      end
    end
  end

endmodule
